// File: rtl/wptr_handler.sv
// Write-side pointer/flag logic of the async FIFO: binary/Gray write pointers,
// full/almost-full/level against the synchronised read pointer, sticky overflow.
module wptr_handler #(
  parameter int PTR_WIDTH     = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     i_Wclk,
  input  logic                     i_Wrst,
  input  logic                     i_W_en,
  input  logic [PTR_WIDTH:0]       i_g_rptr_sync,
  input  logic                     i_clr_ovf,
  output logic [PTR_WIDTH:0]       o_b_wptr,
  output logic [PTR_WIDTH:0]       o_g_wptr,
  output logic                     o_full,
  output logic                     o_afull,
  output logic [PTR_WIDTH:0]       o_level,
  output logic                     o_ovf,
  output logic [OVF_CNT_WIDTH-1:0] o_ovf_cnt
);

  localparam logic [PTR_WIDTH:0] AFULL_LVL = (PTR_WIDTH+1)'(AFULL_THRESH);

  logic                 we;
  logic                 ovf_ev;
  logic [PTR_WIDTH:0]   b_next;
  logic [PTR_WIDTH:0]   g_next;
  logic [PTR_WIDTH:0]   b_rptr;
  logic [PTR_WIDTH:0]   level_next;
  logic [PTR_WIDTH:0]   g_rptr_full;
  logic                 wfull;

  assign we     = i_W_en & ~o_full;
  assign ovf_ev = i_W_en & o_full;

  assign b_next = o_b_wptr + (PTR_WIDTH+1)'(we);
  assign g_next = (b_next >> 1) ^ b_next;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign g_rptr_full = {~i_g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], i_g_rptr_sync[PTR_WIDTH-2:0]};
  assign wfull       = (g_next == g_rptr_full);

  always_comb begin
    b_rptr            = '0;
    b_rptr[PTR_WIDTH] = i_g_rptr_sync[PTR_WIDTH];
    for (int unsigned i = PTR_WIDTH; i > 0; i--) begin
      b_rptr[i-1] = b_rptr[i] ^ i_g_rptr_sync[i-1];
    end
  end

  assign level_next = b_next - b_rptr;

  always_ff @(posedge i_Wclk or posedge i_Wrst) begin
    if (i_Wrst) begin
      o_b_wptr <= '0;
      o_g_wptr <= '0;
      o_full   <= 1'b0;
      o_afull  <= 1'b0;
      o_level  <= '0;
    end else begin
      o_b_wptr <= b_next;
      o_g_wptr <= g_next;
      o_full   <= wfull;
      o_afull  <= (level_next >= AFULL_LVL);
      o_level  <= level_next;
    end
  end

  // A dropped write in the same cycle as a clear restarts the count at one.
  always_ff @(posedge i_Wclk or posedge i_Wrst) begin
    if (i_Wrst) begin
      o_ovf     <= 1'b0;
      o_ovf_cnt <= '0;
    end else if (ovf_ev) begin
      o_ovf <= 1'b1;
      if (i_clr_ovf)
        o_ovf_cnt <= OVF_CNT_WIDTH'(1);
      else if (o_ovf_cnt != '1)
        o_ovf_cnt <= o_ovf_cnt + 1'b1;
    end else if (i_clr_ovf) begin
      o_ovf     <= 1'b0;
      o_ovf_cnt <= '0;
    end
  end

endmodule
